// File: rtl/prog_loader.sv
// Framed byte-stream loader for the accumulator CPU program memory.
// Writes payload bytes, verifies the frame checksum and gates cpu_run.
module prog_loader #(
  parameter logic [7:0]  SYNC    = 8'hA5,
  parameter int unsigned TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       mem_we,
  output logic [7:0] mem_addr,
  output logic [7:0] mem_wdata,
  output logic       cpu_run,
  output logic       busy,
  output logic       load_err
);

  // The counter only ever holds 0..TIMEOUT-1; reaching TIMEOUT is the abort itself.
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM} state_t;

  state_t        state, state_n;
  logic [7:0]    ptr, ptr_n;
  logic [8:0]    rem, rem_n;
  logic [7:0]    sum, sum_n;
  logic [TW-1:0] tcnt, tcnt_n;
  logic          run_n, err_n, we_n, busy_n;
  logic [7:0]    addr_n, wdata_n;
  logic          accept;
  logic [7:0]    sum_add;

  assign accept  = in_valid && in_ready;
  assign sum_add = sum + in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      rem       <= '0;
      sum       <= '0;
      tcnt      <= '0;
      in_ready  <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cpu_run   <= 1'b0;
      busy      <= 1'b0;
      load_err  <= 1'b0;
    end else begin
      state     <= state_n;
      ptr       <= ptr_n;
      rem       <= rem_n;
      sum       <= sum_n;
      tcnt      <= tcnt_n;
      in_ready  <= 1'b1;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      cpu_run   <= run_n;
      busy      <= busy_n;
      load_err  <= err_n;
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    rem_n   = rem;
    sum_n   = sum;
    tcnt_n  = tcnt;
    run_n   = cpu_run;
    err_n   = load_err;
    we_n    = 1'b0;
    addr_n  = mem_addr;
    wdata_n = mem_wdata;

    if (accept) begin
      unique case (state)
        S_IDLE: begin
          if (in_data == SYNC) begin
            state_n = S_ADDR;
            err_n   = 1'b0;
            run_n   = 1'b0;
            sum_n   = '0;
          end
        end
        S_ADDR: begin
          ptr_n   = in_data;
          sum_n   = sum_add;
          state_n = S_LEN;
        end
        S_LEN: begin
          rem_n   = (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
          sum_n   = sum_add;
          state_n = S_DATA;
        end
        S_DATA: begin
          we_n    = 1'b1;
          addr_n  = ptr;
          wdata_n = in_data;
          ptr_n   = ptr + 8'd1;
          sum_n   = sum_add;
          rem_n   = rem - 9'd1;
          if (rem == 9'd1) state_n = S_CSUM;
        end
        S_CSUM: begin
          sum_n   = sum_add;
          state_n = S_IDLE;
          if (sum_add == 8'd0) run_n = 1'b1;
          else                 err_n = 1'b1;
        end
        default: state_n = S_IDLE;
      endcase
    end

    // An accepted byte always beats the timeout in the same cycle.
    if (state == S_IDLE || accept) begin
      tcnt_n = '0;
    end else if (TIMEOUT != 0) begin
      if (tcnt == TLAST) begin
        state_n = S_IDLE;
        err_n   = 1'b1;
        tcnt_n  = '0;
      end else begin
        tcnt_n = tcnt + TW'(1);
      end
    end

    busy_n = (state_n != S_IDLE);
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with a frame-level reference model.
module tb_prog_loader;

  localparam int TO = 8;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       cpu_run;
  logic       busy;
  logic       load_err;

  prog_loader #(.SYNC(8'hA5), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .busy(busy), .load_err(load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state: what the outputs must be right now.
  logic        m_rdy, m_busy, m_run, m_err;
  int          m_idle;
  logic [7:0]  wp, s;
  logic [15:0] exp_q[$];
  logic [7:0]  log_a[$];
  logic [7:0]  pl[$];
  int          wr_cnt = 0;
  bit          seen[256];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("in_ready", in_ready, m_rdy);
    chk("busy", busy, m_busy);
    chk("cpu_run", cpu_run, m_run);
    chk("load_err", load_err, m_err);
    if (mem_we === 1'b1) begin
      logic [15:0] e;
      wr_cnt++;
      seen[mem_addr] = 1'b1;
      log_a.push_back(mem_addr);
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual=%0h:%0h required=none at %0t",
                 mem_addr, mem_wdata, $time);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", mem_addr, e[15:8]);
        chk("wr_data", mem_wdata, e[7:0]);
      end
    end else begin
      chk("mem_we", mem_we, 0);
    end
  end

  task automatic send_b(input logic [7:0] b);
    in_valid = 1'b1;
    in_data  = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    m_idle   = 0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (m_busy) begin
        m_idle++;
        if (m_idle == TO) begin
          m_busy = 1'b0;
          m_err  = 1'b1;
        end
      end
    end
  endtask

  task automatic sync_b();
    send_b(8'hA5);
    m_busy = 1'b1;
    m_run  = 1'b0;
    m_err  = 1'b0;
  endtask

  task automatic hdr(input logic [7:0] a, input logic [7:0] l);
    send_b(a);
    wp = a;
    s  = a;
    send_b(l);
    s = s + l;
  endtask

  task automatic data_b(input logic [7:0] b);
    send_b(b);
    exp_q.push_back({wp, b});
    wp = wp + 8'd1;
    s  = s + b;
  endtask

  task automatic csum_b(input logic [7:0] c);
    send_b(c);
    s      = s + c;
    m_busy = 1'b0;
    m_run  = (s == 8'd0);
    m_err  = (s != 8'd0);
  endtask

  task automatic body(input logic [7:0] a, input logic [7:0] l, input logic [7:0] c);
    hdr(a, l);
    foreach (pl[i]) data_b(pl[i]);
    csum_b(c);
  endtask

  initial begin
    logic [7:0] c;
    int base, nseen, n;
    in_valid = 1'b0;
    in_data  = 8'h00;
    reset    = 1'b1;
    m_rdy = 0; m_busy = 0; m_run = 0; m_err = 0; m_idle = 0;
    wp = 0; s = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", mem_addr, 8'h00);
    chk("rst_wdata", mem_wdata, 8'h00);
    chk("rst_ready", in_ready, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    chk("ready_after_rst", in_ready, 1);

    // Good frame A5 00 03 00 0F 00 EE
    pl = '{8'h00, 8'h0F, 8'h00};
    sync_b();
    body(8'h00, 8'h03, 8'hEE);
    chk("good_run", cpu_run, 1);
    chk("good_err", load_err, 0);
    chk("good_busy", busy, 0);
    n = log_a.size();
    chk("good_a0", log_a[n-3], 8'h00);
    chk("good_a2", log_a[n-1], 8'h02);

    // Bad checksum, then a good reload clears the error at SYNC
    sync_b();
    body(8'h00, 8'h03, 8'hEF);
    chk("bad_run", cpu_run, 0);
    chk("bad_err", load_err, 1);
    chk("bad_pending", exp_q.size(), 0);
    sync_b();
    chk("sync_clears_err", load_err, 0);
    body(8'h00, 8'h03, 8'hEE);
    chk("reload_run", cpu_run, 1);

    // Address wrap FE..00
    pl = '{8'h11, 8'h22, 8'h33};
    sync_b();
    body(8'hFE, 8'h03, 8'h99);
    n = log_a.size();
    chk("wrap_a0", log_a[n-3], 8'hFE);
    chk("wrap_a1", log_a[n-2], 8'hFF);
    chk("wrap_a2", log_a[n-1], 8'h00);
    chk("wrap_run", cpu_run, 1);

    // LEN = 0 means 256 bytes
    pl.delete();
    c = 8'h00;
    for (int i = 0; i < 256; i++) begin
      pl.push_back(8'(i * 3 + 1));
      c = c + 8'(i * 3 + 1);
    end
    c = 8'h00 - c;
    foreach (seen[i]) seen[i] = 1'b0;
    base = wr_cnt;
    sync_b();
    body(8'h00, 8'h00, c);
    nseen = 0;
    foreach (seen[i]) if (seen[i]) nseen++;
    chk("len0_writes", wr_cnt - base, 256);
    chk("len0_coverage", nseen, 256);
    chk("len0_run", cpu_run, 1);

    // Timeout abort after TO idle cycles
    sync_b();
    hdr(8'h10, 8'h02);
    idle(TO - 1);
    chk("to_still_busy", busy, 1);
    idle(1);
    chk("to_busy", busy, 0);
    chk("to_err", load_err, 1);
    chk("to_run", cpu_run, 0);
    idle(3);

    // A byte on the last idle cycle prevents the abort
    sync_b();
    hdr(8'h10, 8'h02);
    idle(TO - 1);
    data_b(8'h55);
    chk("to_saved_busy", busy, 1);
    chk("to_saved_err", load_err, 0);
    data_b(8'h66);
    csum_b(8'h33);
    chk("to_saved_run", cpu_run, 1);

    // Junk in IDLE is ignored; SYNC drops cpu_run at its edge
    send_b(8'h00);
    send_b(8'h5A);
    chk("junk_run", cpu_run, 1);
    chk("junk_busy", busy, 0);
    sync_b();
    chk("reload_drop_run", cpu_run, 0);
    chk("reload_busy", busy, 1);
    pl = '{8'h01, 8'h02};
    body(8'h30, 8'h02, 8'hCB);
    chk("reload2_run", cpu_run, 1);

    // Reset in the middle of DATA
    sync_b();
    hdr(8'h20, 8'h03);
    data_b(8'h44);
    @(negedge clk);
    #1;
    reset = 1'b1;
    m_rdy = 0; m_busy = 0; m_run = 0; m_err = 0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_we", mem_we, 0);
    chk("arst_addr", mem_addr, 8'h00);
    chk("arst_wdata", mem_wdata, 8'h00);
    chk("arst_ready", in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    m_rdy = 1'b1;
    pl = '{8'hAA, 8'hBB, 8'hCC};
    sync_b();
    body(8'h20, 8'h03, 8'hAC);
    n = log_a.size();
    chk("post_rst_a0", log_a[n-3], 8'h20);
    chk("post_rst_a2", log_a[n-1], 8'h22);
    chk("post_rst_run", cpu_run, 1);
    idle(2);
    chk("final_pending", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
